pipe_registers: RTL and testbench

//  Fixed-latency delay line: a chain of NUMBER_OF_STAGES registers, each
//  BIT_WIDTH wide. The value at pipe_in appears at pipe_out exactly

---
 rtl/pipe_registers.sv | 54 +++++
 tb/tb_pipe_registers.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_registers.sv
// pipe_registers: fixed-latency delay line of NUMBER_OF_STAGES registers, BIT_WIDTH bits each.
// Carries side-band bits alongside a datapath pipeline; the reset input is active-high despite its name.
`default_nettype none

module pipe_registers #(
  parameter int BIT_WIDTH        = 1,
  parameter int NUMBER_OF_STAGES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BIT_WIDTH-1:0] pipe_in,
  output logic [BIT_WIDTH-1:0] pipe_out
);

  if (BIT_WIDTH < 1) begin : g_bad_width
    $error("pipe_registers: BIT_WIDTH must be >= 1");
  end

  if (NUMBER_OF_STAGES < 0) begin : g_bad_stages
    $error("pipe_registers: NUMBER_OF_STAGES must be >= 0");
    assign pipe_out = '0;
    logic unused_inputs;
    assign unused_inputs = clk ^ rst_n ^ (^pipe_in);
  end else if (NUMBER_OF_STAGES == 0) begin : g_wire
    // Zero-latency build: clock and reset are intentionally ignored.
    assign pipe_out = pipe_in;
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
  end else begin : g_chain
    for (genvar k = 0; k < NUMBER_OF_STAGES; k++) begin : g_stage
      logic [BIT_WIDTH-1:0] stage_d;
      logic [BIT_WIDTH-1:0] stage_q;

      if (k == 0) begin : g_head
        assign stage_d = pipe_in;
      end else begin : g_tail
        assign stage_d = g_stage[k-1].stage_q;
      end

      always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
          stage_q <= '0;
        end else begin
          stage_q <= stage_d;
        end
      end
    end

    assign pipe_out = g_stage[NUMBER_OF_STAGES-1].stage_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_pipe_registers.sv
// tb_pipe_registers: directed checks of pipe_registers at depths 13, 4, 1 and 0.
// Outputs are sampled at the falling edge, i.e. the value the next rising edge would capture downstream.
`default_nettype none

module tb_pipe_registers;

  logic       clk;
  logic       rst;
  logic [2:0] a_in,  a_out;   // BIT_WIDTH=3, N=13
  logic [7:0] b_in,  b_out;   // BIT_WIDTH=8, N=4
  logic       c_in,  c_out;   // BIT_WIDTH=1, N=1
  logic [7:0] d_in,  d_out;   // BIT_WIDTH=8, N=0

  int total = 0;
  int bad   = 0;

  pipe_registers #(.BIT_WIDTH(3), .NUMBER_OF_STAGES(13)) u_a (
    .clk(clk), .rst_n(rst), .pipe_in(a_in), .pipe_out(a_out));
  pipe_registers #(.BIT_WIDTH(8), .NUMBER_OF_STAGES(4)) u_b (
    .clk(clk), .rst_n(rst), .pipe_in(b_in), .pipe_out(b_out));
  pipe_registers #(.BIT_WIDTH(1), .NUMBER_OF_STAGES(1)) u_c (
    .clk(clk), .rst_n(rst), .pipe_in(c_in), .pipe_out(c_out));
  pipe_registers #(.BIT_WIDTH(8), .NUMBER_OF_STAGES(0)) u_d (
    .clk(clk), .rst_n(rst), .pipe_in(d_in), .pipe_out(d_out));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [7:0] b_in;
    logic [7:0] b_exp;
    logic       c_in;
    logic       c_exp;
    logic [7:0] d_in;
    logic [7:0] d_exp;
  } vec_t;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  // Asserted 1 unit after a rising edge, held across two edges, released 1 unit after an edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_async_a", {5'd0, a_out}, 8'h00);
    chk("rst_async_b", b_out, 8'h00);
    edge_step();
    edge_step();
    rst = 1'b0;
  endtask

  vec_t vecs [12];
  logic [7:0] pre  [6];
  logic [7:0] post [6];
  logic [7:0] exp8;

  initial begin
    vecs[0]  = '{8'h00, 8'h00, 1'b1, 1'b0, 8'hF0, 8'hF0};
    vecs[1]  = '{8'h01, 8'h00, 1'b0, 1'b1, 8'hF1, 8'hF1};
    vecs[2]  = '{8'h02, 8'h00, 1'b1, 1'b0, 8'hF2, 8'hF2};
    vecs[3]  = '{8'h03, 8'h00, 1'b0, 1'b1, 8'hF3, 8'hF3};
    vecs[4]  = '{8'h04, 8'h00, 1'b1, 1'b0, 8'hF4, 8'hF4};
    vecs[5]  = '{8'h05, 8'h01, 1'b0, 1'b1, 8'hF5, 8'hF5};
    vecs[6]  = '{8'h06, 8'h02, 1'b1, 1'b0, 8'hF6, 8'hF6};
    vecs[7]  = '{8'h07, 8'h03, 1'b0, 1'b1, 8'hF7, 8'hF7};
    vecs[8]  = '{8'h08, 8'h04, 1'b1, 1'b0, 8'hF8, 8'hF8};
    vecs[9]  = '{8'h09, 8'h05, 1'b0, 1'b1, 8'hF9, 8'hF9};
    vecs[10] = '{8'h0A, 8'h06, 1'b1, 1'b0, 8'hFA, 8'hFA};
    vecs[11] = '{8'h0B, 8'h07, 1'b0, 1'b1, 8'hFB, 8'hFB};
    pre  = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
    post = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    rst  = 1'b1;
    a_in = '0; b_in = '0; c_in = 1'b0; d_in = '0;
    edge_step();
    edge_step();
    chk("por_a", {5'd0, a_out}, 8'h00);
    chk("por_b", b_out, 8'h00);
    chk("por_c", {7'd0, c_out}, 8'h00);
    rst = 1'b0;

    // Fill every chain, then reset mid-cycle with no clock edge.
    a_in = 3'b111; b_in = 8'h55; c_in = 1'b1;
    for (int i = 0; i < 15; i++) edge_step();
    chk("full_a", {5'd0, a_out}, 8'h07);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_clear_a", {5'd0, a_out}, 8'h00);
    chk("async_clear_b", b_out, 8'h00);
    chk("async_clear_c", {7'd0, c_out}, 8'h00);
    d_in = 8'h3C;
    #1;
    chk("n0_in_reset", d_out, 8'h3C);
    edge_step();
    chk("held_a_e1", {5'd0, a_out}, 8'h00);
    edge_step();
    chk("held_a_e2", {5'd0, a_out}, 8'h00);
    rst = 1'b0;
    a_in = 3'b110;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      chk("post_rst_a", {5'd0, a_out}, (i == 13) ? 8'h06 : 8'h00);
      edge_step();
    end

    // Single-cycle pulse through the 13-deep chain.
    do_reset();
    for (int i = 0; i < 30; i++) begin
      a_in = (i == 0) ? 3'b101 : 3'b000;
      @(negedge clk);
      chk("pulse_a", {5'd0, a_out}, (i == 13) ? 8'h05 : 8'h00);
      edge_step();
    end

    // Table: counting stream (N=4), toggle (N=1), combinational (N=0).
    do_reset();
    for (int i = 0; i < 12; i++) begin
      b_in = vecs[i].b_in;
      c_in = vecs[i].c_in;
      d_in = vecs[i].d_in;
      @(negedge clk);
      chk("vec_b", b_out, vecs[i].b_exp);
      chk("vec_c", {7'd0, c_out}, {7'd0, vecs[i].c_exp});
      chk("vec_d", d_out, vecs[i].d_exp);
      edge_step();
    end

    // Reset with words in flight: none of A1..A6 may reappear.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      b_in = pre[i];
      @(negedge clk);
      exp8 = (i >= 4) ? pre[i-4] : 8'h00;
      chk("inflight_b", b_out, exp8);
      edge_step();
    end
    b_in = 8'hA7;
    rst  = 1'b1;
    #1;
    chk("inflight_clear_b", b_out, 8'h00);
    edge_step();
    b_in = 8'hA8;
    edge_step();
    chk("inflight_held_b", b_out, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      b_in = (i < 6) ? post[i] : 8'h00;
      @(negedge clk);
      exp8 = (i >= 4) ? post[i-4] : 8'h00;
      chk("after_inflight_b", b_out, exp8);
      edge_step();
    end

    // Reset rising on the same edge that would capture 0xFF.
    b_in = 8'hFF;
    @(posedge clk);
    rst = 1'b1;
    #1;
    chk("same_edge_b", b_out, 8'h00);
    b_in = 8'h00;
    edge_step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_ff_b", b_out, 8'h00);
      edge_step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
